// File: rtl/set_pkg.sv
// Shared encodings, field widths and the driver FSM states for the SET pattern driver.
package set_pkg;

    localparam int COORD_W   = 4;
    localparam int CENTRAL_W = 6 * COORD_W;
    localparam int RADIUS_W  = 3 * COORD_W;
    localparam int CAND_W    = 8;
    localparam int CNT_W     = 7;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_UNION  = 2'b01;
    localparam logic [1:0] MODE_DIFF   = 2'b10;
    localparam logic [1:0] MODE_INTER  = 2'b11;

    localparam logic [1:0] STAT_RUN   = 2'b00;
    localparam logic [1:0] STAT_PASS  = 2'b01;
    localparam logic [1:0] STAT_FAIL  = 2'b10;
    localparam logic [1:0] STAT_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_VALID,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/set_timeout_cnt.sv
// Watchdog counter: clear/load/count with a flag raised once the count sits at TERMINAL-1.
module set_timeout_cnt #(
    parameter int TERMINAL = 4096,
    parameter int CNT_W    = $clog2(TERMINAL) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    input  logic             i_enable,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/set_pattern_driver.sv
// On-chip initiator that replays stored SET patterns, checks each candidate count and keeps run statistics.
module set_pattern_driver
    import set_pkg::*;
#(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int MAX_ERR = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    output logic [ADDR_W-1:0]    pat_addr,
    output logic                 pat_rd,
    input  logic [CENTRAL_W-1:0] pat_central,
    input  logic [RADIUS_W-1:0]  pat_radius,
    input  logic [CAND_W-1:0]    pat_expected,
    output logic                 en,
    output logic [CENTRAL_W-1:0] central,
    output logic [RADIUS_W-1:0]  radius,
    output logic [1:0]           mode,
    input  logic                 busy,
    input  logic                 valid,
    input  logic [CAND_W-1:0]    candidate,
    output logic                 running,
    output logic [1:0]           status,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [ADDR_W-1:0]    first_fail_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PAT - 1);
    localparam logic [CNT_W-1:0]  ERR_LIMIT = CNT_W'(MAX_ERR);
    localparam int                TMO_W     = $clog2(TIMEOUT) + 1;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_W-1:0]     r_idx;
    logic [CENTRAL_W-1:0]  r_central;
    logic [RADIUS_W-1:0]   r_radius;
    logic [CAND_W-1:0]     r_exp;
    logic [CAND_W-1:0]     r_cand;
    logic [1:0]            r_mode;
    logic [1:0]            r_status;
    logic [CNT_W-1:0]      r_errCnt;
    logic [CNT_W-1:0]      r_passCnt;
    logic [ADDR_W-1:0]     r_firstFail;
    logic                  w_en;
    logic                  w_match;
    logic                  w_abortErr;
    logic                  w_tmoClear;
    logic                  w_tmoEnable;
    logic                  w_tmoTerm;
    logic [CNT_W-1:0]      w_errNext;

    assign w_match    = (r_cand == r_exp);
    assign w_errNext  = sat_inc(r_errCnt);
    assign w_abortErr = !w_match && (w_errNext >= ERR_LIMIT);

    set_timeout_cnt #(
        .TERMINAL (TIMEOUT),
        .CNT_W    (TMO_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tmoClear),
        .i_load     (1'b0),
        .i_loadVal  ('0),
        .i_enable   (w_tmoEnable),
        .o_terminal (w_tmoTerm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The watchdog is zeroed on the en cycle so it counts only the wait for valid, never the busy stall.
    always_comb begin
        w_nextState = r_state;
        w_en        = 1'b0;
        w_tmoClear  = 1'b0;
        w_tmoEnable = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_nextState = ST_FETCH;
            ST_FETCH:         w_nextState = ST_LOAD;
            ST_LOAD:          w_nextState = ST_ISSUE;
            ST_ISSUE: begin
                if (!busy) begin
                    w_en        = 1'b1;
                    w_tmoClear  = 1'b1;
                    w_nextState = ST_WAIT_VALID;
                end
            end
            ST_WAIT_VALID: begin
                w_tmoEnable = 1'b1;
                if (valid)          w_nextState = ST_CHECK;
                else if (w_tmoTerm) w_nextState = ST_DONE;
            end
            ST_CHECK: begin
                if (w_abortErr || r_idx == LAST_IDX) w_nextState = ST_DONE;
                else                                 w_nextState = ST_FETCH;
            end
            default:          w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_central   <= '0;
            r_radius    <= '0;
            r_exp       <= '0;
            r_cand      <= '0;
            r_mode      <= MODE_SINGLE;
            r_status    <= STAT_RUN;
            r_errCnt    <= '0;
            r_passCnt   <= '0;
            r_firstFail <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mode      <= cfg_mode;
                        r_idx       <= '0;
                        r_status    <= STAT_RUN;
                        r_errCnt    <= '0;
                        r_passCnt   <= '0;
                        r_firstFail <= '0;
                    end
                end
                ST_LOAD: begin
                    r_central <= pat_central;
                    r_radius  <= pat_radius;
                    r_exp     <= pat_expected;
                end
                ST_WAIT_VALID: begin
                    if (valid)          r_cand   <= candidate;
                    else if (w_tmoTerm) r_status <= STAT_ABORT;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_passCnt <= sat_inc(r_passCnt);
                    end else begin
                        r_errCnt <= w_errNext;
                        if (r_errCnt == '0) r_firstFail <= r_idx;
                    end
                    // The abort limit outranks the end-of-run verdict on the final pattern.
                    if (w_abortErr)            r_status <= STAT_ABORT;
                    else if (r_idx == LAST_IDX) r_status <= (w_match && r_errCnt == '0) ? STAT_PASS : STAT_FAIL;
                    else                        r_idx    <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign en             = w_en;
    assign pat_rd         = (r_state == ST_FETCH);
    assign pat_addr       = r_idx;
    assign central        = r_central;
    assign radius         = r_radius;
    assign mode           = r_mode;
    assign running        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign status         = r_status;
    assign err_cnt        = r_errCnt;
    assign pass_cnt       = r_passCnt;
    assign first_fail_idx = r_firstFail;

endmodule

// File: tb/tb_set_pattern_driver.sv
// Bench for set_pattern_driver: a pattern memory and SET responder model drive randomized runs,
// and each run's outcome is predicted from the pattern/response tables alone.
`timescale 1ns/1ps
module tb_set_pattern_driver;

    localparam int NUM_PAT  = 16;
    localparam int ADDR_W   = 4;
    localparam int MAX_ERR  = 10;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_CYC = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        cfg_mode;
    logic [ADDR_W-1:0] pat_addr;
    logic              pat_rd;
    logic [23:0]       pat_central;
    logic [11:0]       pat_radius;
    logic [7:0]        pat_expected;
    logic              en;
    logic [23:0]       central;
    logic [11:0]       radius;
    logic [1:0]        mode;
    logic              busy;
    logic              valid;
    logic [7:0]        candidate;
    logic              running;
    logic [1:0]        status;
    logic [6:0]        err_cnt;
    logic [6:0]        pass_cnt;
    logic [ADDR_W-1:0] first_fail_idx;

    int compared   = 0;
    int mismatched = 0;

    logic [23:0] memCentral [NUM_PAT];
    logic [11:0] memRadius  [NUM_PAT];
    logic [7:0]  memExp     [NUM_PAT];
    logic [7:0]  respVal    [NUM_PAT];

    int          hangIdx = -1, holdBusy = 0, cycle = 0, txIdx = 0, curTx = 0, rspCnt = -1;
    logic        rdPending = 1'b0, prevEn = 1'b0, prevRunning = 1'b0;
    logic [ADDR_W-1:0] rdAddr = '0;
    logic [1:0]  expMode = 2'b00;
    int          enCount, enDouble, enWhileBusy, busErr, maxAddr, firstRdAddr;
    int          firstEnCycle, lastEnCycle, doneCycle, startCycle;

    logic [1:0]  mStatus;
    int          mPass, mErr, mFirst, mLast;

    always #5 clk = ~clk;

    set_pattern_driver #(
        .NUM_PAT (NUM_PAT),
        .ADDR_W  (ADDR_W),
        .MAX_ERR (MAX_ERR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_mode       (cfg_mode),
        .pat_addr       (pat_addr),
        .pat_rd         (pat_rd),
        .pat_central    (pat_central),
        .pat_radius     (pat_radius),
        .pat_expected   (pat_expected),
        .en             (en),
        .central        (central),
        .radius         (radius),
        .mode           (mode),
        .busy           (busy),
        .valid          (valid),
        .candidate      (candidate),
        .running        (running),
        .status         (status),
        .err_cnt        (err_cnt),
        .pass_cnt       (pass_cnt),
        .first_fail_idx (first_fail_idx)
    );

    // Pattern memory (one-cycle read latency), SET responder and protocol monitor, stepped once per cycle.
    initial begin
        busy = 1'b0; valid = 1'b0; candidate = '0;
        pat_central = '0; pat_radius = '0; pat_expected = '0;
        forever begin
            @(posedge clk); #1;
            cycle++;
            if (rspCnt >= 0) rspCnt++;
            busy = 1'b0; valid = 1'b0; candidate = 8'($urandom);
            if (rdPending) begin
                pat_central = memCentral[rdAddr]; pat_radius = memRadius[rdAddr]; pat_expected = memExp[rdAddr];
            end else begin
                pat_central = 24'($urandom); pat_radius = 12'($urandom); pat_expected = 8'($urandom);
            end
            if (holdBusy > 0) begin
                busy = 1'b1; valid = 1'b1; holdBusy--;
            end
            if (rspCnt >= 1 && rspCnt <= BUSY_CYC) busy = 1'b1;
            if (rspCnt == BUSY_CYC + 1) begin
                if (curTx != hangIdx) begin valid = 1'b1; candidate = respVal[curTx]; end
                rspCnt = -1;
            end
            #1;
            if (rst) rspCnt = -1;
            if (en === 1'b1) begin
                enCount++;
                if (firstEnCycle < 0) firstEnCycle = cycle;
                lastEnCycle = cycle;
                if (prevEn) enDouble++;
                if (busy) enWhileBusy++;
                if (rspCnt >= 0 || txIdx >= NUM_PAT) busErr++;
                else if (central !== memCentral[txIdx] || radius !== memRadius[txIdx] || mode !== expMode) busErr++;
                curTx = txIdx; txIdx++; rspCnt = 0;
            end
            prevEn = (en === 1'b1);
            rdPending = (pat_rd === 1'b1); rdAddr = pat_addr;
            if (pat_rd === 1'b1 && int'(pat_addr) > maxAddr) maxAddr = int'(pat_addr);
            if (pat_rd === 1'b1 && firstRdAddr < 0) firstRdAddr = int'(pat_addr);
            if (prevRunning && running === 1'b0 && doneCycle < 0) doneCycle = cycle;
            prevRunning = (running === 1'b1);
        end
    end

    task automatic fillPatterns(input int mismatchPct);
        for (int i = 0; i < NUM_PAT; i++) begin
            memCentral[i] = 24'($urandom);
            memRadius[i]  = 12'($urandom);
            memExp[i]     = 8'($urandom);
            respVal[i]    = ($urandom_range(99) < mismatchPct) ? (memExp[i] ^ 8'($urandom_range(255, 1))) : memExp[i];
        end
    endtask

    task automatic clearStats();
        enCount = 0; enDouble = 0; enWhileBusy = 0; busErr = 0; maxAddr = -1; firstRdAddr = -1;
        firstEnCycle = -1; lastEnCycle = -1; doneCycle = -1; txIdx = 0; hangIdx = -1;
    endtask

    // Run-level prediction straight from the tables: walk patterns in order, stop on hang or error limit.
    task automatic computeModel();
        mStatus = 2'b01; mPass = 0; mErr = 0; mFirst = 0; mLast = NUM_PAT - 1;
        for (int i = 0; i < NUM_PAT; i++) begin
            if (i == hangIdx) begin mStatus = 2'b11; mLast = i; break; end
            if (respVal[i] == memExp[i]) mPass++;
            else begin
                if (mErr == 0) mFirst = i;
                mErr++;
                if (mErr == MAX_ERR) begin mStatus = 2'b11; mLast = i; break; end
            end
        end
        if (mStatus == 2'b01 && mErr > 0) mStatus = 2'b10;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input int holdCycles);
        @(negedge clk);
        cfg_mode = m; expMode = m; start = 1'b1; startCycle = cycle; holdBusy = holdCycles;
        @(negedge clk);
        start = 1'b0; cfg_mode = 2'($urandom);
    endtask

    task automatic waitDone(output bit ok);
        int n = 0;
        while (running === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        ok = (running === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_mode = 2'b00;
        repeat (3) @(negedge clk);
        compared++;
        if ({en, pat_rd, running, status} !== 5'b0) begin
            mismatched++; $display("[TB] FAIL reset_ctrl: got en/rd/run/status=%b want 00000", {en, pat_rd, running, status});
        end
        compared++;
        if ({err_cnt, pass_cnt, first_fail_idx, pat_addr} !== '0) begin
            mismatched++; $display("[TB] FAIL reset_counters: got err=%0d pass=%0d ffi=%0d addr=%0d want all 0", err_cnt, pass_cnt, first_fail_idx, pat_addr);
        end
        compared++;
        if ({central, radius, mode} !== '0) begin
            mismatched++; $display("[TB] FAIL reset_bus: got central=%h radius=%h mode=%b want 0", central, radius, mode);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_pass();
        bit ok;
        fillPatterns(0); clearStats();
        applyStimulus(2'($urandom), 0);
        compared++;
        if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL allpass_running: got %b want 1", running); end
        waitDone(ok); computeModel();
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL allpass_done: run did not finish within 3000 cycles, want finished"); end
        compared++;
        if (status !== 2'b01 || pass_cnt !== 7'(NUM_PAT) || err_cnt !== 7'd0 || first_fail_idx !== '0) begin
            mismatched++; $display("[TB] FAIL allpass_result: got st=%b pass=%0d err=%0d ffi=%0d want st=01 pass=%0d err=0 ffi=0", status, pass_cnt, err_cnt, first_fail_idx, NUM_PAT);
        end
        compared++;
        if (enCount != NUM_PAT || enDouble != 0 || enWhileBusy != 0 || busErr != 0) begin
            mismatched++; $display("[TB] FAIL allpass_protocol: got en=%0d dbl=%0d busyEn=%0d busErr=%0d want %0d/0/0/0", enCount, enDouble, enWhileBusy, busErr, NUM_PAT);
        end
        compared++;
        if (maxAddr != NUM_PAT - 1 || mode !== expMode) begin
            mismatched++; $display("[TB] FAIL allpass_addr_mode: got maxAddr=%0d mode=%b want %0d mode=%b", maxAddr, mode, NUM_PAT - 1, expMode);
        end
        compared++;
        if (firstEnCycle - startCycle != 3) begin
            mismatched++; $display("[TB] FAIL allpass_first_en: got latency %0d want 3", firstEnCycle - startCycle);
        end
    endtask

    task automatic test_single_mismatch();
        bit ok;
        fillPatterns(0); clearStats();
        memExp[1] = 8'h14; respVal[1] = 8'h13;
        applyStimulus(2'b01, 0);
        waitDone(ok); computeModel();
        compared++;
        if (!ok || status !== 2'b10 || err_cnt !== 7'd1 || first_fail_idx !== 4'd1 || pass_cnt !== 7'(NUM_PAT - 1)) begin
            mismatched++; $display("[TB] FAIL single_mismatch: got ok=%0d st=%b err=%0d ffi=%0d pass=%0d want 1/10/1/1/%0d", ok, status, err_cnt, first_fail_idx, pass_cnt, NUM_PAT - 1);
        end
        compared++;
        if (enCount != NUM_PAT || busErr != 0) begin
            mismatched++; $display("[TB] FAIL single_mismatch_en: got en=%0d busErr=%0d want %0d/0", enCount, busErr, NUM_PAT);
        end
    endtask

    task automatic test_random_mismatch();
        bit ok;
        for (int run = 0; run < 4; run++) begin
            fillPatterns(25); clearStats();
            applyStimulus(2'($urandom), 0);
            waitDone(ok); computeModel();
            compared++;
            if (!ok || status !== mStatus || int'(pass_cnt) != mPass || int'(err_cnt) != mErr || int'(first_fail_idx) != mFirst) begin
                mismatched++; $display("[TB] FAIL random_run%0d: got ok=%0d st=%b pass=%0d err=%0d ffi=%0d want st=%b pass=%0d err=%0d ffi=%0d",
                    run, ok, status, pass_cnt, err_cnt, first_fail_idx, mStatus, mPass, mErr, mFirst);
            end
            compared++;
            if (enCount != mLast + 1 || maxAddr != mLast || busErr != 0 || enDouble != 0) begin
                mismatched++; $display("[TB] FAIL random_run%0d_protocol: got en=%0d maxAddr=%0d busErr=%0d dbl=%0d want en=%0d maxAddr=%0d", run, enCount, maxAddr, busErr, enDouble, mLast + 1, mLast);
            end
        end
    endtask

    task automatic test_max_err();
        bit ok;
        fillPatterns(100); clearStats();
        applyStimulus(2'b10, 0);
        waitDone(ok); computeModel();
        compared++;
        if (!ok || status !== 2'b11 || err_cnt !== 7'(MAX_ERR) || pass_cnt !== 7'd0 || first_fail_idx !== '0) begin
            mismatched++; $display("[TB] FAIL maxerr_result: got ok=%0d st=%b err=%0d pass=%0d ffi=%0d want 1/11/%0d/0/0", ok, status, err_cnt, pass_cnt, first_fail_idx, MAX_ERR);
        end
        compared++;
        if (maxAddr != MAX_ERR - 1 || enCount != MAX_ERR) begin
            mismatched++; $display("[TB] FAIL maxerr_addr: got maxAddr=%0d en=%0d want %0d/%0d", maxAddr, enCount, MAX_ERR - 1, MAX_ERR);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        fillPatterns(0); clearStats(); hangIdx = 2;
        applyStimulus(2'b00, 0);
        waitDone(ok); computeModel();
        repeat (20) @(negedge clk);
        compared++;
        if (!ok || status !== 2'b11 || pass_cnt !== 7'd2 || err_cnt !== 7'd0) begin
            mismatched++; $display("[TB] FAIL timeout_result: got ok=%0d st=%b pass=%0d err=%0d want 1/11/2/0", ok, status, pass_cnt, err_cnt);
        end
        compared++;
        if (doneCycle - lastEnCycle != TIMEOUT + 1) begin
            mismatched++; $display("[TB] FAIL timeout_cycles: got en-to-done %0d want %0d", doneCycle - lastEnCycle, TIMEOUT + 1);
        end
        compared++;
        if (enCount != 3 || running !== 1'b0) begin
            mismatched++; $display("[TB] FAIL timeout_no_reissue: got en=%0d running=%b want 3/0", enCount, running);
        end
    endtask

    task automatic test_back_to_back_busy_hold();
        bit ok;
        int n;
        fillPatterns(15); clearStats();
        applyStimulus(2'b11, 50);
        repeat (20) @(negedge clk);
        start = 1'b1; cfg_mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (en !== 1'b0 || pass_cnt !== 7'd0 || err_cnt !== 7'd0 || running !== 1'b1 || mode !== 2'b11) begin
            mismatched++; $display("[TB] FAIL hold_start_ignored: got en=%b pass=%0d err=%0d run=%b mode=%b want 0/0/0/1/11", en, pass_cnt, err_cnt, running, mode);
        end
        n = 0;
        while (enCount < 5 && n < 500) begin @(negedge clk); n++; end
        start = 1'b1; cfg_mode = 2'b01;
        @(negedge clk);
        start = 1'b0;
        waitDone(ok); computeModel();
        compared++;
        if (firstEnCycle - startCycle != 51 || enWhileBusy != 0) begin
            mismatched++; $display("[TB] FAIL hold_first_en: got latency %0d busyEn=%0d want 51/0", firstEnCycle - startCycle, enWhileBusy);
        end
        compared++;
        if (!ok || status !== mStatus || int'(pass_cnt) != mPass || int'(err_cnt) != mErr || int'(first_fail_idx) != mFirst || mode !== 2'b11) begin
            mismatched++; $display("[TB] FAIL hold_result: got ok=%0d st=%b pass=%0d err=%0d ffi=%0d mode=%b want st=%b pass=%0d err=%0d ffi=%0d mode=11",
                ok, status, pass_cnt, err_cnt, first_fail_idx, mode, mStatus, mPass, mErr, mFirst);
        end
        compared++;
        if (enCount != mLast + 1 || busErr != 0) begin
            mismatched++; $display("[TB] FAIL hold_protocol: got en=%0d busErr=%0d want %0d/0", enCount, busErr, mLast + 1);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int n = 0;
        fillPatterns(30); clearStats();
        applyStimulus(2'b01, 0);
        while (!(enCount >= 4 && rspCnt >= 2) && n < 500) begin @(negedge clk); n++; end
        compared++;
        if (rspCnt < 2) begin mismatched++; $display("[TB] FAIL midrun_reach_wait: got en=%0d after %0d cycles want 4", enCount, n); end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({en, running, status, err_cnt, pass_cnt, pat_addr, mode} !== '0) begin
            mismatched++; $display("[TB] FAIL midrun_reset: got en=%b run=%b st=%b err=%0d pass=%0d addr=%0d mode=%b want all 0", en, running, status, err_cnt, pass_cnt, pat_addr, mode);
        end
        rst = 1'b0;
        fillPatterns(20); clearStats();
        applyStimulus(2'b11, 0);
        @(negedge clk);
        compared++;
        if (firstRdAddr != 0 || mode !== 2'b11) begin
            mismatched++; $display("[TB] FAIL midrun_restart: got firstAddr=%0d mode=%b want 0/11", firstRdAddr, mode);
        end
        waitDone(ok); computeModel();
        compared++;
        if (!ok || status !== mStatus || int'(pass_cnt) != mPass || int'(err_cnt) != mErr || int'(first_fail_idx) != mFirst) begin
            mismatched++; $display("[TB] FAIL midrun_rerun: got ok=%0d st=%b pass=%0d err=%0d ffi=%0d want st=%b pass=%0d err=%0d ffi=%0d",
                ok, status, pass_cnt, err_cnt, first_fail_idx, mStatus, mPass, mErr, mFirst);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_single_mismatch();
        test_random_mismatch();
        test_max_err();
        test_timeout();
        test_back_to_back_busy_hold();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
